// File: rtl/latch_seq_pkg.sv
// latch_seq_pkg: shared FSM state type and default phase lengths for the latch write sequencer.
package latch_seq_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    localparam int SETUP_CYC_DEF = 2;
    localparam int OPEN_CYC_DEF  = 4;
    localparam int HOLD_CYC_DEF  = 2;

endpackage

// File: rtl/phase_counter.sv
// phase_counter: 8-bit loadable down-counter with zero flag; stops at zero instead of wrapping.
// Ports: clk, rst_n (async active-low), load/load_val (load has priority), dec (count down), zero (count == 0).
module phase_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != 8'd0)
            count <= count - 8'd1;
    end

    assign zero = (count == 8'd0);

endmodule

// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: hands one word at a time to a transparent latch with setup/open/hold timing.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data upstream handshake;
//        latch_en/latch_data drive the latch; busy = not idle; done = one-cycle completion pulse.
module latch_write_sequencer
    import latch_seq_pkg::*;
#(
    parameter int DATA_W    = 1,
    parameter int SETUP_CYC = SETUP_CYC_DEF,
    parameter int OPEN_CYC  = OPEN_CYC_DEF,
    parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              latch_en,
    output logic [DATA_W-1:0] latch_data,
    output logic              busy,
    output logic              done
);

    state_t     state;
    logic       load;
    logic       dec;
    logic       zero;
    logic [7:0] load_val;

    // Each phase loads (length - 1) on entry; the phase ends on the cycle the counter reads zero.
    // Leaving HOLD reloads 0 so the counter rests at zero while idle.
    always_comb begin
        load     = (state == IDLE) ? (in_valid && in_ready) : zero;
        load_val = (state == IDLE)  ? 8'(SETUP_CYC - 1) :
                   (state == SETUP) ? 8'(OPEN_CYC - 1)  :
                   (state == OPEN)  ? 8'(HOLD_CYC - 1)  : 8'd0;
        dec      = (state != IDLE) && !zero;
    end

    phase_counter u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .dec      (dec),
        .zero     (zero)
    );

    // latch_data is only written in IDLE, where latch_en is already low and stays low into SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            latch_en   <= 1'b0;
            latch_data <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    latch_data <= in_data;
                    state      <= SETUP;
                    busy       <= 1'b1;
                    in_ready   <= 1'b0;
                end
                SETUP: if (zero) begin
                    state    <= OPEN;
                    latch_en <= 1'b1;
                end
                OPEN: if (zero) begin
                    state    <= HOLD;
                    latch_en <= 1'b0;
                end
                HOLD: if (zero) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    done     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb_latch_write_sequencer: scoreboard-driven bench for latch_write_sequencer (default and minimum phase lengths).
module tb_latch_write_sequencer;

    logic clk = 1'b0, rst0 = 1'b0, rst1 = 1'b0, in_valid = 1'b0, in_data = 1'b0, sel = 1'b0;
    logic rdy0, en0, dat0, busy0, done0, rdy1, en1, dat1, busy1, done1;
    logic obs_ready, obs_en, obs_data, obs_busy, obs_done;
    int cyc = 0, checks = 0, errors = 0, S = 2, O = 4, H = 2;

    typedef struct {int t; logic d;} xfer_t;
    xfer_t q[$];
    logic exp_data = 1'b0, prev_data = 1'b0, prev_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign obs_ready = sel ? rdy1  : rdy0;
    assign obs_en    = sel ? en1   : en0;
    assign obs_data  = sel ? dat1  : dat0;
    assign obs_busy  = sel ? busy1 : busy0;
    assign obs_done  = sel ? done1 : done0;

    latch_write_sequencer dut0 (
        .clk(clk), .rst_n(rst0), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .latch_en(en0), .latch_data(dat0), .busy(busy0), .done(done0)
    );

    latch_write_sequencer #(.DATA_W(1), .SETUP_CYC(1), .OPEN_CYC(1), .HOLD_CYC(1)) dut1 (
        .clk(clk), .rst_n(rst1), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .latch_en(en1), .latch_data(dat1), .busy(busy1), .done(done1)
    );

    // Scoreboard monitor: the oldest accepted word determines every expected output this cycle.
    task automatic sample();
        logic m_en, m_busy, m_done;
        int t;
        if ((sel ? rst1 : rst0) !== 1'b1) begin
            q.delete();
            exp_data  = 1'b0;
            prev_data = obs_data;
            prev_en   = obs_en;
            return;
        end
        m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        if (q.size() > 0 && cyc >= q[0].t) begin
            t        = q[0].t;
            exp_data = q[0].d;
            m_busy   = cyc < t + S + O + H;
            m_en     = cyc >= t + S && cyc < t + S + O;
            m_done   = cyc == t + S + O + H;
            if (m_done) void'(q.pop_front());
        end
        checks += 6;
        if (obs_en !== m_en) begin errors++; $display("FAIL mon_latch_en cyc=%0d got=%b exp=%b", cyc, obs_en, m_en); end
        if (obs_busy !== m_busy) begin errors++; $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, obs_busy, m_busy); end
        if (obs_done !== m_done) begin errors++; $display("FAIL mon_done cyc=%0d got=%b exp=%b", cyc, obs_done, m_done); end
        if (obs_ready !== !m_busy) begin errors++; $display("FAIL mon_in_ready cyc=%0d got=%b exp=%b", cyc, obs_ready, !m_busy); end
        if (obs_data !== exp_data) begin errors++; $display("FAIL mon_latch_data cyc=%0d got=%b exp=%b", cyc, obs_data, exp_data); end
        if (obs_data !== prev_data && (obs_en || prev_en)) begin
            errors++; $display("FAIL safety_en_vs_data cyc=%0d data %b->%b en %b->%b", cyc, prev_data, obs_data, prev_en, obs_en);
        end
        prev_data = obs_data;
        prev_en   = obs_en;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
    endtask

    // A transfer happens on the next rising edge when valid is offered while ready is already high.
    task automatic drive(input logic v, input logic d);
        in_valid = v;
        in_data  = d;
        if (v && obs_ready === 1'b1) q.push_back('{t: cyc + 1, d: d});
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60; k++) begin
            tick();
            if (q.size() == 0 && obs_ready === 1'b1) return;
        end
        checks++; errors++;
        $display("FAIL wait_idle timeout cyc=%0d pending=%0d", cyc, q.size());
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks += 5;
        if (en0 !== 1'b0) begin errors++; $display("FAIL rst_latch_en got=%b exp=0", en0); end
        if (dat0 !== 1'b0) begin errors++; $display("FAIL rst_latch_data got=%b exp=0", dat0); end
        if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy0); end
        if (done0 !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done0); end
        if (dut0.u_cnt.count !== 8'd0) begin errors++; $display("FAIL rst_counter got=%0d exp=0", dut0.u_cnt.count); end
        #2 rst0 = 1'b1;
        tick();
        checks++;
        if (rdy0 !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", rdy0); end
    endtask

    task automatic test_single();
        int t, first = -1, n_en = 0, done_at = -1;
        tick();
        drive(1'b1, 1'b1);
        t = cyc + 1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i == 0) drive(1'b0, 1'b0);
            if (obs_en === 1'b1) begin n_en++; if (first < 0) first = cyc - t; end
            if (obs_done === 1'b1) done_at = cyc - t;
        end
        checks += 4;
        if (first != 2) begin errors++; $display("FAIL single_en_start got=%0d exp=2", first); end
        if (n_en != 4) begin errors++; $display("FAIL single_en_len got=%0d exp=4", n_en); end
        if (done_at != 8) begin errors++; $display("FAIL single_done_at got=%0d exp=8", done_at); end
        if (obs_data !== 1'b1) begin errors++; $display("FAIL single_data got=%b exp=1", obs_data); end
    endtask

    task automatic test_back_to_back(input int period, input int cycles);
        int last_t = -1, n_x = 0;
        logic d = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (i > 0) begin
                checks++;
                if (obs_ready !== obs_done) begin errors++; $display("FAIL b2b_ready_vs_done cyc=%0d ready=%b done=%b", cyc, obs_ready, obs_done); end
            end
            if (obs_ready === 1'b1) begin
                if (last_t >= 0) begin
                    checks++;
                    if (cyc + 1 - last_t != period) begin errors++; $display("FAIL b2b_period got=%0d exp=%0d", cyc + 1 - last_t, period); end
                end
                last_t = cyc + 1;
                n_x++;
                d = ~d;
            end
            drive(1'b1, d);
        end
        tick();
        drive(1'b0, 1'b0);
        wait_idle();
        checks++;
        if (n_x < 4) begin errors++; $display("FAIL b2b_count got=%0d exp>=4", n_x); end
    endtask

    task automatic test_ignore_busy();
        tick();
        drive(1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0);
        for (int k = 0; k < 10 && obs_en !== 1'b1; k++) tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0);
            tick();
            checks += 3;
            if (obs_ready !== 1'b0) begin errors++; $display("FAIL ignore_in_ready got=%b exp=0", obs_ready); end
            if (obs_data !== 1'b1) begin errors++; $display("FAIL ignore_data got=%b exp=1", obs_data); end
            if (obs_en !== 1'b1) begin errors++; $display("FAIL ignore_still_open got=%b exp=1", obs_en); end
        end
        drive(1'b0, 1'b0);
        wait_idle();
        checks++;
        if (obs_data !== 1'b1) begin errors++; $display("FAIL ignore_final_data got=%b exp=1", obs_data); end
    endtask

    task automatic test_reset_mid();
        int t, done_at = -1;
        tick();
        drive(1'b1, 1'b1);
        tick();
        drive(1'b0, 1'b0);
        for (int k = 0; k < 10 && obs_en !== 1'b1; k++) tick();
        #2 rst0 = 1'b0;
        #1;
        checks += 5;
        if (en0 !== 1'b0) begin errors++; $display("FAIL midrst_latch_en got=%b exp=0", en0); end
        if (dat0 !== 1'b0) begin errors++; $display("FAIL midrst_latch_data got=%b exp=0", dat0); end
        if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy0); end
        if (done0 !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done0); end
        if (dut0.u_cnt.count !== 8'd0) begin errors++; $display("FAIL midrst_counter got=%0d exp=0", dut0.u_cnt.count); end
        tick();
        #2 rst0 = 1'b1;
        drive(1'b1, 1'b1);
        t = cyc + 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) drive(1'b0, 1'b0);
            if (obs_done === 1'b1) done_at = cyc - t;
        end
        checks++;
        if (done_at != 8) begin errors++; $display("FAIL midrst_recover_done got=%0d exp=8", done_at); end
    endtask

    task automatic test_min_params();
        int t, first = -1, n_en = 0, done_at = -1;
        tick();
        #2 rst0 = 1'b0;
        sel = 1'b1; S = 1; O = 1; H = 1;
        tick();
        #2 rst1 = 1'b1;
        tick();
        drive(1'b1, 1'b1);
        t = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 0) drive(1'b0, 1'b0);
            if (obs_en === 1'b1) begin n_en++; if (first < 0) first = cyc - t; end
            if (obs_done === 1'b1) done_at = cyc - t;
        end
        checks += 3;
        if (first != 1) begin errors++; $display("FAIL min_en_start got=%0d exp=1", first); end
        if (n_en != 1) begin errors++; $display("FAIL min_en_len got=%0d exp=1", n_en); end
        if (done_at != 3) begin errors++; $display("FAIL min_done_at got=%0d exp=3", done_at); end
        test_back_to_back(4, 20);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back(9, 40);
        test_ignore_busy();
        test_reset_mid();
        test_min_params();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
